// File: rtl/burst_sequencer_if.sv
// Control/status bundle between the register block and the burst sequencer.
// The master side is the register interface and datapath; the slave side is the sequencer.
interface burst_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 24
);
  logic             Load;
  logic [1:0]       Mode_in;
  logic [CNT_W-1:0] Burst_Count_in;
  logic [DLY_W-1:0] Trig_Delay_in;
  logic             Ext_Pol;
  logic             Ext_Trig;
  logic             Soft_Trig;
  logic             Stop;
  logic             PCO;
  logic             Wave_Carry;
  logic             Burst_EN;
  logic             Wave_EN;
  logic             Phase_Clr;
  logic             Trig_Out;
  logic             Burst_Active;
  logic             Trig_Overrun;

  modport master (
    output Load, Mode_in, Burst_Count_in, Trig_Delay_in, Ext_Pol,
           Ext_Trig, Soft_Trig, Stop, PCO, Wave_Carry,
    input  Burst_EN, Wave_EN, Phase_Clr, Trig_Out, Burst_Active, Trig_Overrun
  );

  modport slave (
    input  Load, Mode_in, Burst_Count_in, Trig_Delay_in, Ext_Pol,
           Ext_Trig, Soft_Trig, Stop, PCO, Wave_Carry,
    output Burst_EN, Wave_EN, Phase_Clr, Trig_Out, Burst_Active, Trig_Overrun
  );
endinterface

// File: rtl/burst_sequencer.sv
// Burst-mode sequencer: gates the phase path for N waveform cycles after a trigger.
// Optional trigger delay (DELAY state and counter) is built only when BURST_TRIG_DELAY_EN is defined.
module burst_sequencer #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 24
) (
  input  logic                Clock,
  input  logic                Reset,
  burst_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  localparam logic [1:0]       MODE_CONT = 2'b00;
  localparam logic [1:0]       MODE_INT  = 2'b01;
  localparam logic [1:0]       MODE_EXT  = 2'b10;
  localparam logic [1:0]       MODE_SOFT = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] count_r;
  logic             pol_r;
  logic             abort_r;
  logic             sync1_r, sync2_r, sync3_r, ext_edge_r;
  logic [CNT_W-1:0] count_lat_r;
  logic [CNT_W-1:0] cyc_cnt_r;
  logic             burst_en_r, wave_en_r, phase_clr_r, trig_out_r, active_r, overrun_r;
  logic             trig_s;
  logic [CNT_W-1:0] cyc_nxt_s;
`ifdef BURST_TRIG_DELAY_EN
  localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  logic [DLY_W-1:0] delay_r;
  logic [DLY_W-1:0] dly_cnt_r;
`endif

  // Shadow registers; a mode change arms an abort that takes effect one edge later.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mode_r  <= MODE_CONT;
      count_r <= CNT_ZERO;
      pol_r   <= 1'b0;
      abort_r <= 1'b0;
`ifdef BURST_TRIG_DELAY_EN
      delay_r <= DLY_ZERO;
`endif
    end else begin
      abort_r <= bus.Load && (bus.Mode_in != mode_r);
      if (bus.Load) begin
        mode_r  <= bus.Mode_in;
        count_r <= bus.Burst_Count_in;
        pol_r   <= bus.Ext_Pol;
`ifdef BURST_TRIG_DELAY_EN
        delay_r <= bus.Trig_Delay_in;
`endif
      end
    end
  end

  // External trigger synchronizer and registered polarity-selected edge pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      sync3_r    <= 1'b0;
      ext_edge_r <= 1'b0;
    end else begin
      sync1_r    <= bus.Ext_Trig;
      sync2_r    <= sync1_r;
      sync3_r    <= sync2_r;
      ext_edge_r <= pol_r ? (sync3_r & ~sync2_r) : (sync2_r & ~sync3_r);
    end
  end

  // Trigger source mux and saturating cycle-count increment.
  always_comb begin
    trig_s = 1'b0;
    case (mode_r)
      MODE_INT:  trig_s = bus.PCO;
      MODE_EXT:  trig_s = ext_edge_r;
      MODE_SOFT: trig_s = bus.Soft_Trig;
      default:   trig_s = 1'b0;
    endcase
    if (cyc_cnt_r == CNT_MAX) begin
      cyc_nxt_s = cyc_cnt_r;
    end else begin
      cyc_nxt_s = cyc_cnt_r + CNT_ONE;
    end
  end

  // Burst FSM with all outputs registered alongside the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      count_lat_r <= CNT_ZERO;
      cyc_cnt_r   <= CNT_ZERO;
      burst_en_r  <= 1'b0;
      wave_en_r   <= 1'b0;
      phase_clr_r <= 1'b0;
      trig_out_r  <= 1'b0;
      active_r    <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef BURST_TRIG_DELAY_EN
      dly_cnt_r   <= DLY_ZERO;
`endif
    end else begin
      burst_en_r  <= (mode_r == MODE_INT);
      trig_out_r  <= 1'b0;
      phase_clr_r <= 1'b0;
      if (bus.Load) begin
        overrun_r <= 1'b0;
      end else if (trig_s && (state_r != ST_IDLE) && !bus.Stop && !abort_r) begin
        overrun_r <= 1'b1;
      end
      // Stop, a pending mode-change abort, or continuous mode all force IDLE.
      if (bus.Stop || abort_r || (mode_r == MODE_CONT)) begin
        state_r   <= ST_IDLE;
        wave_en_r <= (mode_r == MODE_CONT);
        active_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            wave_en_r <= 1'b0;
            active_r  <= 1'b0;
            if (trig_s) begin
              trig_out_r  <= 1'b1;
              active_r    <= 1'b1;
              cyc_cnt_r   <= CNT_ZERO;
              count_lat_r <= count_r;
`ifdef BURST_TRIG_DELAY_EN
              if (delay_r != DLY_ZERO) begin
                dly_cnt_r <= delay_r;
                state_r   <= ST_DELAY;
              end else begin
                state_r     <= ST_RUN;
                wave_en_r   <= 1'b1;
                phase_clr_r <= 1'b1;
              end
`else
              state_r     <= ST_RUN;
              wave_en_r   <= 1'b1;
              phase_clr_r <= 1'b1;
`endif
            end
          end
`ifdef BURST_TRIG_DELAY_EN
          ST_DELAY: begin
            if (dly_cnt_r == DLY_ONE) begin
              state_r     <= ST_RUN;
              wave_en_r   <= 1'b1;
              phase_clr_r <= 1'b1;
            end else begin
              dly_cnt_r <= dly_cnt_r - DLY_ONE;
            end
          end
`endif
          ST_RUN: begin
            // The carry coinciding with the phase clear belongs to the old phase.
            if (bus.Wave_Carry && !phase_clr_r) begin
              cyc_cnt_r <= cyc_nxt_s;
              if ((count_lat_r != CNT_ZERO) && (cyc_nxt_s == count_lat_r)) begin
                state_r   <= ST_IDLE;
                wave_en_r <= 1'b0;
                active_r  <= 1'b0;
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            wave_en_r <= 1'b0;
            active_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Burst_EN     = burst_en_r;
  assign bus.Wave_EN      = wave_en_r;
  assign bus.Phase_Clr    = phase_clr_r;
  assign bus.Trig_Out     = trig_out_r;
  assign bus.Burst_Active = active_r;
  assign bus.Trig_Overrun = overrun_r;

endmodule
